cordic_rotator_iter: RTL and testbench
======================================

// Module: cordic_rotator_iter
// PURPOSE
//   Iterative rotation-mode CORDIC: rotates vector (x,y) by angle z, steering each
//   micro-rotation by the sign of the residual angle z (not by the sign of y).
//   It is the counterpart of the vectoring stages, which drive y to 0. This block
//   drives z to 0 and leaves the rotated vector in x/y, e.g. cos/sin generation.
//   One shared datapath is reused for ITERS cycles per operation.
//   valid/ready handshake on both input and output sides.
// PARAMETERS
//   ITERS  24  number of micro-rotations, legal range 1..30
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   operand valid
//   in_ready   out  1   block can accept an operand (high only in IDLE)
//   in_x       in   32  signed Q2.29 x
//   in_y       in   32  signed Q2.29 y
//   in_z       in   32  signed Q3.29 angle in radians, legal range [-pi, +pi]
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   out_x      out  32  signed Q2.29 rotated x, scaled by K (~1.64676)
//   out_y      out  32  signed Q2.29 rotated y, scaled by K
//   out_z      out  32  signed Q3.29 residual angle, near 0
// BEHAVIOUR
//   Reset: state=IDLE, iteration counter=0, x/y/z regs=0.
//     in_ready=1, out_valid=0, out_x/out_y/out_z=0.
//   FSM states are IDLE -> RUN -> DONE -> IDLE.
//   IDLE: the load edge is the rising edge with in_valid & in_ready; it goes to RUN, cnt=0.
//     Quadrant pre-rotation at load, with PI = 1686629713 (Q3.29):
//       z > PI/2  : x=-in_x, y=-in_y, z=in_z-PI
//       z < -PI/2 : x=-in_x, y=-in_y, z=in_z+PI
//       otherwise : the regs load unchanged.
//     Boundary: z equal to +/-PI/2 takes no pre-rotation.
//   RUN: iteration i=cnt is applied on each edge.
//     Direction: if z[31]==0 then d=+1, else d=-1.
//     Update: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
//     Shifts are arithmetic; all adds are 32-bit two's complement with wrap.
//     There is no saturation; |x|,|y| <= 1.0 at input cannot overflow.
//     ATAN[i] = round(atan(2^-i) * 2^29), a constant table for i = 0..29.
//     ATAN[0] = 421657428.
//     After the edge with i=ITERS-1 the FSM goes to DONE. A RUN operation lasts
//     exactly ITERS edges.
//   DONE: out_valid=1, and out_x/y/z equal the final regs and stay stable.
//     The edge with out_ready=1 goes to IDLE, and out_valid drops after that edge.
//     While out_ready=0 the FSM holds in DONE indefinitely with outputs unchanged.
//   Latency: load at edge k gives out_valid=1 after edge k+ITERS.
//     Throughput is 1 operation per ITERS+2 cycles with out_ready tied high.
//   in_ready is 0 in RUN and DONE; in_valid there is ignored and not queued.
//   No gain compensation: callers pre-scale the input by 1/K for unit output.
//   Async reset during RUN/DONE aborts the operation and no result is emitted.
//     All outputs return to reset values immediately.
//   in_z outside [-PI, PI] is out of contract and gives an undefined result, with no hang:
//     the FSM still completes and reaches DONE.
// TESTING
//   T1 pi/6 rotation. Stimulus: x=326016437 (1/K), y=0, z=281104952, ITERS=24.
//      -> out_x=464943848 and out_y=268435456 (each +/-64 LSB), |out_z|<64.
//   T2 zero angle. Stimulus: x=268435456, y=0, z=0.
//      -> out_x=round(0.5*K*2^29)+/-64, |out_y|<=64.
//   T3 pre-rotation. Stimulus: x=326016437, y=0, z=3pi/4=1264972285.
//      -> out_x=-379625062, out_y=+379625062 (+/-64).
//      Also run z=-3pi/4 -> out_x=-379625062, out_y=-379625062.
//   T4 backpressure. Hold out_ready=0 for 10 cycles in DONE.
//      -> outputs stable and in_ready=0 for the whole hold.
//      Then out_ready=1 -> one out_valid handshake, then in_ready=1.
//   T5 reset mid-RUN. Assert rst at cnt=5 of an operation.
//      -> out_valid=0, in_ready=1, outputs=0.
//      A new operand after reset completes correctly per T1.
//   T6 latency/throughput. Back-to-back operands with out_ready=1.
//      -> out_valid exactly ITERS edges after each load, no dropped or duplicated results.

Source files
------------

// File: rtl/cordic_rotator_iter.sv
// Iterative rotation-mode CORDIC. One shared add/shift datapath runs ITERS
// micro-rotations per operand, each steered by the sign of the residual angle.
module cordic_rotator_iter #(
    parameter int ITERS = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_x,
    input  logic signed [31:0] in_y,
    input  logic signed [31:0] in_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_x,
    output logic signed [31:0] out_y,
    output logic signed [31:0] out_z
);

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Angles in Q3.29; HALF_PI is round(pi/2 * 2^29), so +/-HALF_PI itself is not pre-rotated.
    localparam logic signed [31:0] PI          = 32'sd1686629713;
    localparam logic signed [31:0] HALF_PI     = 32'sd843314857;
    localparam logic signed [31:0] NEG_HALF_PI = -32'sd843314857;

    function automatic logic signed [31:0] atan_lut(input logic [CNT_W-1:0] i);
        logic signed [31:0] v;
        case (i)
            5'd0:    v = 32'sd421657428;
            5'd1:    v = 32'sd248918915;
            5'd2:    v = 32'sd131521918;
            5'd3:    v = 32'sd66762579;
            5'd4:    v = 32'sd33510843;
            5'd5:    v = 32'sd16771758;
            5'd6:    v = 32'sd8387925;
            5'd7:    v = 32'sd4194219;
            5'd8:    v = 32'sd2097141;
            5'd9:    v = 32'sd1048575;
            5'd10:   v = 32'sd524288;
            5'd11:   v = 32'sd262144;
            5'd12:   v = 32'sd131072;
            5'd13:   v = 32'sd65536;
            5'd14:   v = 32'sd32768;
            5'd15:   v = 32'sd16384;
            5'd16:   v = 32'sd8192;
            5'd17:   v = 32'sd4096;
            5'd18:   v = 32'sd2048;
            5'd19:   v = 32'sd1024;
            5'd20:   v = 32'sd512;
            5'd21:   v = 32'sd256;
            5'd22:   v = 32'sd128;
            5'd23:   v = 32'sd64;
            5'd24:   v = 32'sd32;
            5'd25:   v = 32'sd16;
            5'd26:   v = 32'sd8;
            5'd27:   v = 32'sd4;
            5'd28:   v = 32'sd2;
            5'd29:   v = 32'sd1;
            default: v = 32'sd0;
        endcase
        return v;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [31:0] x_q, x_d;
    logic signed [31:0] y_q, y_d;
    logic signed [31:0] z_q, z_d;
    logic signed [31:0] x_sh, y_sh, atan_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        x_sh    = x_q >>> cnt_q;
        y_sh    = y_q >>> cnt_q;
        atan_i  = atan_lut(cnt_q);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    // Fold angles beyond +/-pi/2 into CORDIC's convergence range.
                    if (in_z > HALF_PI) begin
                        x_d = -in_x;
                        y_d = -in_y;
                        z_d = in_z - PI;
                    end else if (in_z < NEG_HALF_PI) begin
                        x_d = -in_x;
                        y_d = -in_y;
                        z_d = in_z + PI;
                    end else begin
                        x_d = in_x;
                        y_d = in_y;
                        z_d = in_z;
                    end
                end
            end
            S_RUN: begin
                if (!z_q[31]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_z     = z_q;

endmodule

// File: tb/tb_cordic_rotator_iter.sv
// Directed bench for cordic_rotator_iter: fixed operands with hand-computed
// trigonometric results, backpressure, mid-operation reset and back-to-back timing.
module tb_cordic_rotator_iter;

    localparam int ITERS = 24;
    localparam int TCLK  = 10;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_x, in_y, in_z;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_x, out_y, out_z;

    int     checks;
    int     errors;
    longint last_load_t;

    cordic_rotator_iter #(.ITERS(ITERS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z)
    );

    initial clk = 1'b0;
    always #(TCLK/2) clk = ~clk;

    function automatic bit near(input logic signed [31:0] a, input logic signed [31:0] b, input int tol);
        longint diff;
        diff = longint'(a) - longint'(b);
        return (diff <= tol) && (diff >= -tol);
    endfunction

    task automatic chk_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp, input int tol);
        checks++;
        assert (near(got, exp, tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads one operand, waits for the result and checks latency. With hold set,
    // out_ready stays low for 10 cycles in DONE before the result is accepted.
    task automatic run_op(input string tag, input logic signed [31:0] x, input logic signed [31:0] y,
                          input logic signed [31:0] z, input bit hold,
                          output logic signed [31:0] ox, output logic signed [31:0] oy,
                          output logic signed [31:0] oz);
        int lat;
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        out_ready = hold ? 1'b0 : 1'b1;
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_z      = z;
        tick();
        last_load_t = $time;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk_eq({tag, " latency"}, lat, ITERS);
        ox = out_x;
        oy = out_y;
        oz = out_z;
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                in_valid = 1'b1;
                in_x     = 32'sd12345;
                in_z     = 32'sd999;
                tick();
                chk_eq({tag, " hold out_valid"}, 32'(out_valid), 32'sd1);
                chk_eq({tag, " hold in_ready"}, 32'(in_ready), 32'sd0);
                chk_eq({tag, " hold out_x"}, out_x, ox);
                chk_eq({tag, " hold out_y"}, out_y, oy);
                chk_eq({tag, " hold out_z"}, out_z, oz);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        chk_eq({tag, " out_valid drop"}, 32'(out_valid), 32'sd0);
        chk_eq({tag, " in_ready back"}, 32'(in_ready), 32'sd1);
    endtask

    initial begin
        logic signed [31:0] rx, ry, rz;
        longint t0, t1, t2;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;

        // Reset state
        #3;
        chk_eq("reset in_ready", 32'(in_ready), 32'sd1);
        chk_eq("reset out_valid", 32'(out_valid), 32'sd0);
        chk_eq("reset out_x", out_x, 32'sd0);
        chk_eq("reset out_y", out_y, 32'sd0);
        chk_eq("reset out_z", out_z, 32'sd0);
        #10;
        rst = 1'b0;
        tick();

        // T1: rotate 1/K by pi/6 -> (cos, sin)
        run_op("T1", 32'sd326016437, 32'sd0, 32'sd281104952, 1'b0, rx, ry, rz);
        chk_near("T1 out_x", rx, 32'sd464943848, 64);
        chk_near("T1 out_y", ry, 32'sd268435456, 64);
        chk_near("T1 out_z", rz, 32'sd0, 63);

        // T2: zero angle leaves the vector on the x axis, scaled by K
        run_op("T2", 32'sd268435456, 32'sd0, 32'sd0, 1'b0, rx, ry, rz);
        chk_near("T2 out_x", rx, 32'sd442048841, 64);
        chk_near("T2 out_y", ry, 32'sd0, 64);

        // T3: angles beyond pi/2 exercise the quadrant pre-rotation
        run_op("T3p", 32'sd326016437, 32'sd0, 32'sd1264972285, 1'b0, rx, ry, rz);
        chk_near("T3p out_x", rx, -32'sd379625062, 64);
        chk_near("T3p out_y", ry, 32'sd379625062, 64);
        run_op("T3n", 32'sd326016437, 32'sd0, -32'sd1264972285, 1'b0, rx, ry, rz);
        chk_near("T3n out_x", rx, -32'sd379625062, 64);
        chk_near("T3n out_y", ry, -32'sd379625062, 64);

        // Exactly pi/2 and -pi/2: (0, +1) and (0, -1)
        run_op("HPp", 32'sd326016437, 32'sd0, 32'sd843314857, 1'b0, rx, ry, rz);
        chk_near("HPp out_x", rx, 32'sd0, 64);
        chk_near("HPp out_y", ry, 32'sd536870912, 64);
        run_op("HPn", 32'sd326016437, 32'sd0, -32'sd843314857, 1'b0, rx, ry, rz);
        chk_near("HPn out_x", rx, 32'sd0, 64);
        chk_near("HPn out_y", ry, -32'sd536870912, 64);

        // T4: backpressure in DONE, in_valid pulses ignored
        run_op("T4", 32'sd326016437, 32'sd0, 32'sd281104952, 1'b1, rx, ry, rz);
        chk_near("T4 out_x", rx, 32'sd464943848, 64);
        chk_near("T4 out_y", ry, 32'sd268435456, 64);

        // T5: asynchronous reset at cnt=5
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 32'sd326016437;
        in_y      = 32'sd0;
        in_z      = 32'sd281104952;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk_eq("T5 busy in_ready", 32'(in_ready), 32'sd0);
        rst = 1'b1;
        #1;
        chk_eq("T5 out_valid", 32'(out_valid), 32'sd0);
        chk_eq("T5 in_ready", 32'(in_ready), 32'sd1);
        chk_eq("T5 out_x", out_x, 32'sd0);
        chk_eq("T5 out_y", out_y, 32'sd0);
        chk_eq("T5 out_z", out_z, 32'sd0);
        #2;
        rst = 1'b0;
        tick();
        chk_eq("T5 no result", 32'(out_valid), 32'sd0);
        run_op("T5r", 32'sd326016437, 32'sd0, 32'sd281104952, 1'b0, rx, ry, rz);
        chk_near("T5r out_x", rx, 32'sd464943848, 64);
        chk_near("T5r out_y", ry, 32'sd268435456, 64);

        // T6: back-to-back operands, one result each, ITERS+2 cycle period
        run_op("T6a", 32'sd326016437, 32'sd0, 32'sd281104952, 1'b0, rx, ry, rz);
        t0 = last_load_t;
        chk_near("T6a out_y", ry, 32'sd268435456, 64);
        run_op("T6b", 32'sd326016437, 32'sd0, -32'sd281104952, 1'b0, rx, ry, rz);
        t1 = last_load_t;
        chk_near("T6b out_y", ry, -32'sd268435456, 64);
        run_op("T6c", 32'sd268435456, 32'sd0, 32'sd0, 1'b0, rx, ry, rz);
        t2 = last_load_t;
        chk_near("T6c out_x", rx, 32'sd442048841, 64);
        chk_eq("T6 period ab", 32'(t1 - t0), 32'((ITERS + 2) * TCLK));
        chk_eq("T6 period bc", 32'(t2 - t1), 32'((ITERS + 2) * TCLK));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
